// File: rtl/bus_sched_pkg.sv
// bus_sched shared types and default sizing.
// Used by the scheduler RTL and its bench.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_TENURE = 16;
  localparam int DEF_TURNAROUND = 1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first request after i_last, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_breq,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [$clog2(N_REQ)-1:0] o_pick,
  output logic                     o_valid
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] w_idx;

  // Scan farthest-first so the nearest request overwrites.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = IW'((int'(i_last) + i) % N_REQ);
      if (i_breq[w_idx]) begin
        o_pick  = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_sched.sv
// Round-robin bus scheduler with bounded tenure
// and a fixed idle turnaround between owners.
module bus_sched
  import bus_sched_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         breq,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     bus_busy,
  output logic                     timeout_err,
  input  logic                     scan_in0,
  input  logic                     scan_en,
  output logic                     scan_out0
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(MAX_TENURE + 1);

  state_t           r_state, w_state_nx;
  logic [N_REQ-1:0] r_grant, w_grant_nx;
  logic [IW-1:0]    r_owner, w_owner_nx;
  logic [IW-1:0]    r_last, w_last_nx;
  logic [TW-1:0]    r_tenure, w_tenure_nx;
  logic [1:0]       r_turn, w_turn_nx;
  logic             r_tmo, w_tmo_nx;

  logic [IW-1:0]    w_pick;
  logic             w_valid;
  logic [N_REQ-1:0] w_onehot;
  logic             w_own_req;
  logic             w_expired;
  logic             w_unused_scan;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_breq  (breq),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_own_req = breq[r_owner];
  assign w_expired = (r_tenure == TW'(MAX_TENURE));

  always_comb begin
    w_state_nx  = r_state;
    w_grant_nx  = r_grant;
    w_owner_nx  = r_owner;
    w_last_nx   = r_last;
    w_tenure_nx = r_tenure;
    w_turn_nx   = r_turn;
    w_tmo_nx    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_grant_nx  = w_onehot;
          w_owner_nx  = w_pick;
          w_tenure_nx = TW'(1);
          w_state_nx  = GRANT;
        end
      end
      GRANT: begin
        // Release wins over expiry, so no error when both coincide.
        if (!w_own_req || w_expired) begin
          w_grant_nx = '0;
          w_last_nx  = r_owner;
          w_turn_nx  = 2'(TURNAROUND - 1);
          w_tmo_nx   = w_own_req;
          w_state_nx = TURN;
        end else begin
          w_tenure_nx = r_tenure + TW'(1);
        end
      end
      TURN: begin
        if (r_turn != 2'd0) begin
          w_turn_nx = r_turn - 2'd1;
        end else if (w_valid) begin
          w_grant_nx  = w_onehot;
          w_owner_nx  = w_pick;
          w_tenure_nx = TW'(1);
          w_state_nx  = GRANT;
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_grant_nx = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_last   <= IW'(N_REQ - 1);
      r_tenure <= '0;
      r_turn   <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_owner  <= w_owner_nx;
      r_last   <= w_last_nx;
      r_tenure <= w_tenure_nx;
      r_turn   <= w_turn_nx;
      r_tmo    <= w_tmo_nx;
    end
  end

  assign grant         = r_grant;
  assign owner         = r_owner;
  assign bus_busy      = |r_grant;
  assign timeout_err   = r_tmo;
  assign scan_out0     = 1'b0;
  assign w_unused_scan = scan_in0 ^ scan_en;

endmodule
